bridge_out_collector: RTL
=========================

# bridge_out_collector

Double-buffered result collector that sits directly downstream of the bridge buffer controller and its systolic array. It captures each finished result block of matrix C, which arrives as a one-cycle pulse in row-major block order with no backpressure. It stores one complete C matrix per bank and streams the matrix out over a valid/ready interface to the next attention stage. While one bank drains, the other bank fills.

## Interface
- DATA_WIDTH, 16, bits per matrix element
- BLOCK_SIZE, 2, block edge; WORD_WIDTH = DATA_WIDTH*BLOCK_SIZE*BLOCK_SIZE (localparam)
- ROW_Y, 4, block rows of C
- COL_Y, 2, block columns of C; DEPTH = ROW_Y*COL_Y, ADDR_WIDTH = $clog2(DEPTH) (localparams)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  one-cycle pulse, one result block present (driven by controller out_valid)
- in_data  in  WORD_WIDTH  result block, captured when in_valid=1
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word when out_valid&&out_ready
- out_data  out  WORD_WIDTH  streamed block
- out_last  out  1  marks the final word of a matrix
- bank_full  out  2  per-bank full flags
- overflow  out  1  sticky flag: an input word was dropped

## Operation
- Two banks, each DEPTH words. Write side: wr_bank, wr_addr.
- Write on in_valid:
  - If bank_full[wr_bank]=0, write in_data at {wr_bank, wr_addr}.
  - If wr_addr==DEPTH-1: set bank_full[wr_bank], toggle wr_bank, set wr_addr=0. Otherwise increment wr_addr.
- If in_valid arrives while bank_full[wr_bank]=1, drop the word, set overflow=1 and leave the pointers unchanged.
- Read FSM (rd_state_t), read bank rd_bank:
  - R_IDLE: go to R_STREAM when bank_full[rd_bank]=1.
  - R_STREAM: issue reads with read index counters rd_r (block row, 0..ROW_Y-1) and rd_c (block column, 0..COL_Y-1).
- Read-enable rule: enb = R_STREAM && words_issued<DEPTH && (!out_valid || out_ready). The memory output register holds when enb=0.
- Output handshake:
  - out_valid is set on an edge where enb=1.
  - Otherwise it is cleared on a handshake.
  - out_last is registered together with the data, and is 1 for issue index DEPTH-1.
- Release: a handshake with out_last=1 clears bank_full[rd_bank], toggles rd_bank and returns the FSM to R_IDLE.
- Simultaneous events:
  - A release and a bank-completing write on the other bank in the same cycle both take effect.
  - If in_valid meets a release of bank wr_bank in the same cycle, the write is accepted. The released data is already held in the output register.
- Arithmetic: address = bank*DEPTH + rd_r*COL_Y + rd_c. Counters wrap at their limits; no widths beyond ADDR_WIDTH+1.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, bank_full=2'b00, overflow=0, wr_bank=rd_bank=0, all counters 0, FSM in R_IDLE. Memory contents are not reset.
- Reset asserted mid-operation discards both banks immediately. The first in_valid after reset deasserts writes address 0 of bank 0.
- Latency: the edge capturing the last word of a bank (E0) sets bank_full. The FSM enters R_STREAM at E1. out_valid is 1 after E2.
- With out_ready held high, throughput is 1 word per cycle. Reading DEPTH words takes DEPTH cycles.
- Gap between back-to-back matrices: out_valid is low for 2 cycles after the last handshake.
- out_data, out_last and out_valid are stable while out_valid=1 && out_ready=0.

## Configuration
- BRIDGE_OUT_TRANSPOSE_EN defined: reads are column-major (rd_c outer, rd_r inner). The downstream stage receives C^T block order, usable as a north-side operand.
- Not defined: reads are row-major (rd_r outer, rd_c inner), identical to arrival order.
- The write side is unaffected by the macro.

## Structure
- Shared package bridge_pkg holds:
  - rd_state_t {R_IDLE, R_STREAM}
  - a WORD_WIDTH helper function
  - the BLOCK_SIZE default constant
- Sub-module bridge_sdp_ram:
  - simple dual-port memory, 2*DEPTH x WORD_WIDTH
  - port A: write
  - port B: synchronous read with enable, 1-cycle latency, output register holds when enb=0

## Test plan
- Reset/idle: rst pulse mid-stream -> all outputs 0 immediately, bank_full=00; the next 8 writes land in bank 0.
- Row-major (macro off, ROW_Y=4, COL_Y=2): in_data=0..7 pulses, out_ready=1 -> out_valid 2 cycles after the 8th write, out_data 0,1,...,7 on consecutive cycles, out_last on 7.
- Transpose (macro on, same stimulus) -> out_data order 0,2,4,6,1,3,5,7, out_last on 7.
- Backpressure: out_ready toggled randomly -> no word lost or duplicated, data held stable while stalled.
- Ping-pong/overflow: 24 back-to-back pulses with out_ready=0 -> bank_full=11 after word 16, words 17..24 dropped, overflow=1 and sticky.
- Simultaneous release: last handshake of bank 0 in the same cycle as in_valid to bank 0 (after bank 1 full) -> write accepted, overflow stays 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the bridge result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bridge_pkg;

   // Default block edge of the systolic array result blocks.
   localparam int BLOCK_SIZE_DEF = 2;

   // Read-side FSM of the output collector.
   typedef enum logic [0:0] {
      R_IDLE   = 1'b0,
      R_STREAM = 1'b1
   } rd_state_t;

   // Bits in one result block word.
   function automatic int word_width(input int data_width, input int block_size);
      return data_width * block_size * block_size;
   endfunction

endpackage

// File: rtl/bridge_sdp_ram.sv
// Simple dual-port memory: port A writes, port B reads into an output register.
// Latency: 1 cycle from enb to doutb.
// Backpressure: doutb holds its value whenever enb=0.
//
// Ports:
//   clk, rst          clock, async active-high reset (output register only)
//   wea/addra/dina    write port
//   enb/addrb/doutb   registered read port
module bridge_sdp_ram #(
   parameter int WIDTH = 64,
   parameter int WORDS = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wea,
   input  logic [AW-1:0]    addra,
   input  logic [WIDTH-1:0] dina,
   input  logic             enb,
   input  logic [AW-1:0]    addrb,
   output logic [WIDTH-1:0] doutb
);

   logic [WIDTH-1:0] mem [WORDS];
   logic [WIDTH-1:0] doutb_d;
   logic [WIDTH-1:0] doutb_q;

   // Storage itself is never reset.
   always_ff @(posedge clk) begin
      if (wea) begin
         mem[addra] <= dina;
      end
   end

   always_comb begin
      doutb_d = doutb_q;
      if (enb) begin
         doutb_d = mem[addrb];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         doutb_q <= '0;
      end else begin
         doutb_q <= doutb_d;
      end
   end

   assign doutb = doutb_q;

endmodule

// File: rtl/bridge_out_collector.sv
// Double-buffered collector: captures C result blocks into two banks, streams each full bank out.
// Latency: bank-completing write at E0 -> out_valid high after E2; 1 word/cycle while out_ready=1.
// Backpressure: none on input (words dropped and overflow set when the target bank is full); output valid/ready.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid, in_data                one-cycle result block pulse
//   out_valid, out_ready, out_data   streamed block handshake
//   out_last                         final word of a matrix
//   bank_full[1:0], overflow         bank status, sticky drop flag
// Build option: BRIDGE_OUT_TRANSPOSE_EN selects column-major read order.
module bridge_out_collector
   import bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
   parameter int ROW_Y      = 4,
   parameter int COL_Y      = 2,
   localparam int WORD_WIDTH = word_width(DATA_WIDTH, BLOCK_SIZE),
   localparam int DEPTH      = ROW_Y * COL_Y,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [1:0]            bank_full,
   output logic                  overflow
);

   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(ROW_Y - 1);
   localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(COL_Y - 1);
   localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);
   localparam logic [AW1-1:0]        DEPTH_W   = AW1'(DEPTH);
   localparam logic [AW1-1:0]        LAST_W    = AW1'(DEPTH - 1);
   localparam logic [AW1-1:0]        COL_W     = AW1'(COL_Y);
   localparam logic [AW1-1:0]        W_ONE     = AW1'(1);

   logic                  wr_bank_q, wr_bank_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic                  overflow_q, overflow_d;
   rd_state_t             rd_state_q, rd_state_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0] rd_r_q, rd_r_d;
   logic [ADDR_WIDTH-1:0] rd_c_q, rd_c_d;
   logic [AW1-1:0]        issued_q, issued_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;

   logic           hs, release_ev, wr_en, enb;
   logic [AW1-1:0] wr_ram_addr, rd_idx, rd_ram_addr;

   assign hs         = out_valid_q && out_ready;
   assign release_ev = hs && out_last_q;
   assign enb        = (rd_state_q == R_STREAM) && (issued_q < DEPTH_W) && (!out_valid_q || out_ready);

   // Write side. A release of the bank being targeted frees it in the same
   // cycle, so the incoming word is accepted rather than dropped.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_addr_d   = wr_addr_q;
      bank_full_d = bank_full_q;
      overflow_d  = overflow_q;
      wr_en       = in_valid && (!bank_full_q[wr_bank_q] || (release_ev && (rd_bank_q == wr_bank_q)));
      if (release_ev) begin
         bank_full_d[rd_bank_q] = 1'b0;
      end
      if (wr_en) begin
         if (wr_addr_q == LAST_ADDR) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_addr_d              = '0;
         end else begin
            wr_addr_d = wr_addr_q + A_ONE;
         end
      end else if (in_valid) begin
         overflow_d = 1'b1;
      end
   end

   assign wr_ram_addr = wr_bank_q ? (DEPTH_W + {1'b0, wr_addr_q}) : {1'b0, wr_addr_q};
   assign rd_idx      = ({1'b0, rd_r_q} * COL_W) + {1'b0, rd_c_q};
   assign rd_ram_addr = rd_bank_q ? (DEPTH_W + rd_idx) : rd_idx;

   // Read side: issue DEPTH reads, then wait for the last word to be taken.
   always_comb begin
      rd_state_d  = rd_state_q;
      rd_bank_d   = rd_bank_q;
      rd_r_d      = rd_r_q;
      rd_c_d      = rd_c_q;
      issued_d    = issued_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      case (rd_state_q)
         R_IDLE: begin
            if (bank_full_q[rd_bank_q]) begin
               rd_state_d = R_STREAM;
            end
         end
         R_STREAM: begin
            if (release_ev) begin
               rd_state_d = R_IDLE;
               rd_bank_d  = ~rd_bank_q;
               issued_d   = '0;
               rd_r_d     = '0;
               rd_c_d     = '0;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      if (enb) begin
         issued_d    = issued_q + W_ONE;
         out_valid_d = 1'b1;
         out_last_d  = (issued_q == LAST_W);
`ifdef BRIDGE_OUT_TRANSPOSE_EN
         // Column-major: walk down a block column before moving right.
         if (rd_r_q == ROW_LAST) begin
            rd_r_d = '0;
            rd_c_d = (rd_c_q == COL_LAST) ? '0 : rd_c_q + A_ONE;
         end else begin
            rd_r_d = rd_r_q + A_ONE;
         end
`else
         // Row-major: same order as arrival.
         if (rd_c_q == COL_LAST) begin
            rd_c_d = '0;
            rd_r_d = (rd_r_q == ROW_LAST) ? '0 : rd_r_q + A_ONE;
         end else begin
            rd_c_d = rd_c_q + A_ONE;
         end
`endif
      end else if (hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q   <= 1'b0;
         wr_addr_q   <= '0;
         bank_full_q <= 2'b00;
         overflow_q  <= 1'b0;
         rd_state_q  <= R_IDLE;
         rd_bank_q   <= 1'b0;
         rd_r_q      <= '0;
         rd_c_q      <= '0;
         issued_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         wr_addr_q   <= wr_addr_d;
         bank_full_q <= bank_full_d;
         overflow_q  <= overflow_d;
         rd_state_q  <= rd_state_d;
         rd_bank_q   <= rd_bank_d;
         rd_r_q      <= rd_r_d;
         rd_c_q      <= rd_c_d;
         issued_q    <= issued_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   bridge_sdp_ram #(
      .WIDTH (WORD_WIDTH),
      .WORDS (2 * DEPTH),
      .AW    (AW1)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .wea   (wr_en),
      .addra (wr_ram_addr),
      .dina  (in_data),
      .enb   (enb),
      .addrb (rd_ram_addr),
      .doutb (out_data)
   );

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign bank_full = bank_full_q;
   assign overflow  = overflow_q;

endmodule
